dpe_route_lookup_arb: RTL and testbench

Round-robin arbiter and sequencer for the single lookup port of dpe_route_mem, shared among NUM_REQ egress lookup clients (one per DPE lane/port).
- Issues one routing lookup per cycle, tracks in-flight requests through the fixed memory latency, and returns each result to the client that issued it.
- Implements a config-freeze handshake: CSR routing-table writes are granted only when no lookup is in flight, so a lookup never sees a half-updated rule.

---
 rtl/dpe_route_lookup_arb.sv | 166 ++++++++++++++++
 tb/tb_dpe_route_lookup_arb.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpe_route_lookup_arb.sv
// Round-robin lookup arbiter and config-freeze sequencer for dpe_route_mem.
// Optional counters: define DPE_ROUTE_ARB_STATS_EN.
module dpe_route_lookup_arb #(
  parameter int NUM_REQ    = 4,
  parameter int LOOKUP_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*32-1:0] req_ip,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic                 resp_hit,
  output logic [2:0]           resp_dst,
  output logic [7:0]           resp_peer,
  output logic                 resp_bypass,
  output logic                 mem_req_valid,
  output logic [31:0]          mem_req_ip,
  input  logic                 mem_resp_hit,
  input  logic [2:0]           mem_resp_dst,
  input  logic [7:0]           mem_resp_peer,
  input  logic                 mem_resp_bypass,
  input  logic                 cfg_wr_req,
  output logic                 cfg_wr_gnt,
  output logic                 busy,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_freeze_stall
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOOKUP_LAT + 3);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] rr_ptr, gnt_id, idx;
  logic [PW:0]   sum;
  logic          found, arb_en, hs, resp_dec;
  logic [CW-1:0] count, count_nxt;

  logic [LOOKUP_LAT:0] tag_v;
  logic [PW-1:0]       tag_id [LOOKUP_LAT+1];

  // reset gates arbitration so no handshake is seen while rst is low
  assign arb_en = rst && (state == IDLE) && !cfg_wr_req;

  always_comb begin
    found  = 1'b0;
    gnt_id = rr_ptr;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign hs = arb_en && found;

  always_comb begin
    req_ready = '0;
    if (hs)
      req_ready[gnt_id] = 1'b1;
  end

  assign resp_dec = |resp_valid;

  always_comb begin
    count_nxt = count;
    unique case ({hs, resp_dec})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: ;
    endcase
  end

  // drain completes when the last response pulses, not one cycle later
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (cfg_wr_req) state_nxt = DRAIN;
      DRAIN:
        if (!cfg_wr_req)          state_nxt = IDLE;
        else if (count_nxt == '0) state_nxt = GRANT;
      GRANT:
        if (!cfg_wr_req) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  assign cfg_wr_gnt = (state == GRANT);
  assign busy       = (count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      count         <= '0;
      tag_v         <= '0;
      for (int k = 0; k <= LOOKUP_LAT; k++)
        tag_id[k] <= '0;
      mem_req_valid <= 1'b0;
      mem_req_ip    <= '0;
      resp_valid    <= '0;
      resp_hit      <= 1'b0;
      resp_dst      <= '0;
      resp_peer     <= '0;
      resp_bypass   <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      mem_req_valid <= hs;
      if (hs) begin
        mem_req_ip <= req_ip[{gnt_id, 5'b0} +: 32];
        rr_ptr     <= (gnt_id == PW'(NUM_REQ-1)) ?
                      '0 : gnt_id + 1'b1;
      end
      tag_v[0]  <= hs;
      tag_id[0] <= gnt_id;
      for (int k = 1; k <= LOOKUP_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      resp_valid <= '0;
      if (tag_v[LOOKUP_LAT]) begin
        resp_valid[tag_id[LOOKUP_LAT]] <= 1'b1;
        resp_hit    <= mem_resp_hit;
        resp_dst    <= mem_resp_dst;
        resp_peer   <= mem_resp_peer;
        resp_bypass <= mem_resp_bypass;
      end
    end
  end

`ifdef DPE_ROUTE_ARB_STATS_EN
  logic stall;
  assign stall = (|req_valid) &&
                 ((state != IDLE) || cfg_wr_req);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_lookups      <= '0;
      stat_freeze_stall <= '0;
    end else begin
      if (hs && stat_lookups != '1)
        stat_lookups <= stat_lookups + 32'd1;
      if (stall && stat_freeze_stall != '1)
        stat_freeze_stall <= stat_freeze_stall + 32'd1;
    end
  end
`else
  assign stat_lookups      = '0;
  assign stat_freeze_stall = '0;
`endif

endmodule

// File: tb/tb_dpe_route_lookup_arb.sv
// Self-checking bench for dpe_route_lookup_arb: vector table,
// hand-written freeze/reset sequences and a randomized model check.
module tb_dpe_route_lookup_arb;

  localparam int N   = 4;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_ip = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic            resp_hit, resp_bypass;
  logic [2:0]      resp_dst;
  logic [7:0]      resp_peer;
  logic            mem_req_valid;
  logic [31:0]     mem_req_ip;
  logic            mem_resp_hit, mem_resp_bypass;
  logic [2:0]      mem_resp_dst;
  logic [7:0]      mem_resp_peer;
  logic            cfg_wr_req = 1'b0;
  logic            cfg_wr_gnt, busy;
  logic [31:0]     stat_lookups, stat_freeze_stall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpe_route_lookup_arb #(.NUM_REQ(N), .LOOKUP_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ip(req_ip),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_dst(resp_dst),
    .resp_peer(resp_peer), .resp_bypass(resp_bypass),
    .mem_req_valid(mem_req_valid), .mem_req_ip(mem_req_ip),
    .mem_resp_hit(mem_resp_hit), .mem_resp_dst(mem_resp_dst),
    .mem_resp_peer(mem_resp_peer),
    .mem_resp_bypass(mem_resp_bypass),
    .cfg_wr_req(cfg_wr_req), .cfg_wr_gnt(cfg_wr_gnt),
    .busy(busy), .stat_lookups(stat_lookups),
    .stat_freeze_stall(stat_freeze_stall)
  );

  // route table stand-in: {hit, dst, peer, bypass}
  function automatic logic [12:0] mem_f(input logic [31:0] ip);
    return {ip[0], ip[2:0] ^ 3'b010, ip[7:0] + 8'h14, ip[31]};
  endfunction

  function automatic logic [31:0] ipc(input int i);
    return 32'h0A00_0100 + 32'(i) * 32'h4000_0033;
  endfunction

  logic        mv [LAT];
  logic [31:0] mi [LAT];
  logic [12:0] nz;

  always @(posedge clk) begin
    nz    <= 13'($urandom);
    mv[0] <= mem_req_valid;
    mi[0] <= mem_req_ip;
    for (int k = 1; k < LAT; k++) begin
      mv[k] <= mv[k-1];
      mi[k] <= mi[k-1];
    end
  end

  assign {mem_resp_hit, mem_resp_dst, mem_resp_peer,
          mem_resp_bypass} = mv[LAT-1] ? mem_f(mi[LAT-1]) : nz;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [12:0] resp_f();
    return {resp_hit, resp_dst, resp_peer, resp_bypass};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " req_ready"}, req_ready, 0);
    chk({tag, " resp_valid"}, resp_valid, 0);
    chk({tag, " resp_fields"}, resp_f(), 0);
    chk({tag, " mem_req_valid"}, mem_req_valid, 0);
    chk({tag, " mem_req_ip"}, mem_req_ip, 0);
    chk({tag, " cfg_wr_gnt"}, cfg_wr_gnt, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " stat_lookups"}, stat_lookups, 0);
    chk({tag, " stat_freeze_stall"}, stat_freeze_stall, 0);
  endtask

  task automatic set_ips();
    for (int i = 0; i < N; i++)
      req_ip[32*i +: 32] = ipc(i);
  endtask

  // leaves the bench in the cycle where rst has just been released
  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    cfg_wr_req = 1'b0;
    repeat (3) tick();
    #1;
    chk_zero("reset");
    rst = 1'b1;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    repeat (n) tick();
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic [N-1:0] exp;
  } vec_t;

  task automatic run_table();
    vec_t tbl[10];
    tbl[0] = '{4'b1111, 4'b0001};
    tbl[1] = '{4'b1001, 4'b1000};
    tbl[2] = '{4'b1001, 4'b0001};
    tbl[3] = '{4'b0000, 4'b0000};
    tbl[4] = '{4'b0001, 4'b0001};
    tbl[5] = '{4'b0110, 4'b0010};
    tbl[6] = '{4'b0110, 4'b0100};
    tbl[7] = '{4'b0011, 4'b0001};
    tbl[8] = '{4'b0100, 4'b0100};
    tbl[9] = '{4'b1000, 4'b1000};
    do_reset();
    set_ips();
    for (int i = 0; i < 10; i++) begin
      tick();
      req_valid = tbl[i].rv;
      #1;
      chk($sformatf("tbl%0d req_ready", i), req_ready, tbl[i].exp);
      if (i > 0) begin
        chk($sformatf("tbl%0d mem_req_valid", i),
            mem_req_valid, tbl[i-1].exp != 0);
        if (tbl[i-1].exp != 0)
          chk($sformatf("tbl%0d mem_req_ip", i), mem_req_ip,
              ipc($clog2(tbl[i-1].exp)));
      end
    end
    drain(5);
  endtask

  task automatic seq_single();
    do_reset();
    tick();
    req_valid = 4'b0100;
    req_ip[64 +: 32] = 32'h0A00_0001;
    #1;
    chk("single req_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    #1;
    chk("single mem_req_valid", mem_req_valid, 1);
    chk("single mem_req_ip", mem_req_ip, 32'h0A00_0001);
    chk("single busy", busy, 1);
    tick();
    #1;
    chk("single early resp", resp_valid, 0);
    tick();
    #1;
    chk("single resp_valid", resp_valid, 4'b0100);
    chk("single resp_fields", resp_f(), {1'b1, 3'd3, 8'h15, 1'b0});
    tick();
    #1;
    chk("single resp_off", resp_valid, 0);
    chk("single hold", resp_f(), {1'b1, 3'd3, 8'h15, 1'b0});
    chk("single idle busy", busy, 0);
  endtask

  task automatic seq_all();
    do_reset();
    set_ips();
    for (int k = 0; k < 16; k++) begin
      tick();
      req_valid = 4'b1111;
      #1;
      chk("all req_ready", req_ready, N'(1) << (k % N));
      chk("all busy", busy, k != 0);
      if (k >= 1)
        chk("all mem_req_ip", mem_req_ip, ipc((k - 1) % N));
      if (k >= 3) begin
        chk("all resp_valid", resp_valid, N'(1) << ((k - 3) % N));
        chk("all resp_fields", resp_f(), mem_f(ipc((k - 3) % N)));
      end
    end
    drain(5);
  endtask

  task automatic seq_freeze();
    do_reset();
    set_ips();
    tick();
    req_valid = 4'b0010;
    #1;
    chk("frz grant1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1101;
    cfg_wr_req = 1'b1;
    #1;
    chk("frz cfg priority", req_ready, 0);
    chk("frz gnt t1", cfg_wr_gnt, 0);
    tick();
    #1;
    chk("frz drain ready", req_ready, 0);
    chk("frz gnt t2", cfg_wr_gnt, 0);
    tick();
    #1;
    chk("frz resp1", resp_valid, 4'b0010);
    chk("frz gnt t3", cfg_wr_gnt, 0);
    tick();
    #1;
    chk("frz gnt t4", cfg_wr_gnt, 1);
    chk("frz busy t4", busy, 0);
    chk("frz ready t4", req_ready, 0);
    tick();
    #1;
    chk("frz gnt t5", cfg_wr_gnt, 1);
    tick();
    cfg_wr_req = 1'b0;
    #1;
    chk("frz gnt release", cfg_wr_gnt, 1);
    chk("frz ready release", req_ready, 0);
    tick();
    #1;
    chk("frz gnt off", cfg_wr_gnt, 0);
    chk("frz resume rr", req_ready, 4'b0100);
    drain(5);
  endtask

  task automatic seq_same_cycle();
    do_reset();
    tick();
    req_valid = 4'b0001;
    cfg_wr_req = 1'b1;
    #1;
    chk("same ready0", req_ready, 0);
    tick();
    #1;
    chk("same gnt c1", cfg_wr_gnt, 0);
    chk("same ready c1", req_ready, 0);
    tick();
    #1;
    chk("same gnt c2", cfg_wr_gnt, 1);
    tick();
    cfg_wr_req = 1'b0;
    #1;
    chk("same gnt c3", cfg_wr_gnt, 1);
    chk("same ready c3", req_ready, 0);
    tick();
    #1;
    chk("same gnt c4", cfg_wr_gnt, 0);
    chk("same resume", req_ready, 4'b0001);
    drain(5);
  endtask

  task automatic seq_abort();
    do_reset();
    tick();
    req_valid = 4'b0001;
    #1;
    chk("abort grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    cfg_wr_req = 1'b1;
    #1;
    chk("abort cfg", req_ready, 0);
    tick();
    cfg_wr_req = 1'b0;
    #1;
    chk("abort drain", req_ready, 0);
    tick();
    #1;
    chk("abort resume", req_ready, 4'b0010);
    chk("abort no gnt", cfg_wr_gnt, 0);
    drain(5);
  endtask

  task automatic seq_reset_inflight();
    do_reset();
    tick();
    req_valid = 4'b0001;
    #1;
    chk("rstf grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("rstf grant1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1111;
    rst = 1'b0;
    tick();
    #1;
    chk_zero("rstf");
    rst = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      chk("rstf no resp", resp_valid, 0);
      chk("rstf busy", busy, 0);
    end
  endtask

  typedef struct {
    int          c;
    logic [31:0] ip;
    int          due;
  } pend_t;

  task automatic run_random(input int ncyc);
    pend_t       q[$];
    logic        pending [N];
    logic [31:0] pip [N];
    int          mptr = 0;
    int          g;
    int          j;
    logic        exp_mv = 1'b0;
    logic [31:0] exp_mip = '0;
    logic [12:0] lastf = '0;
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    do_reset();
    for (int k = 0; k < ncyc; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && ($urandom % 3 == 0)) begin
          pending[i] = 1'b1;
          pip[i] = $urandom;
        end
        req_valid[i] = pending[i];
        if (pending[i]) req_ip[32*i +: 32] = pip[i];
      end
      #1;
      chk("rnd busy", busy, q.size() != 0);
      chk("rnd cfg_wr_gnt", cfg_wr_gnt, 0);
      chk("rnd mem_req_valid", mem_req_valid, exp_mv);
      chk("rnd mem_req_ip", mem_req_ip, exp_mip);
      if (q.size() != 0 && q[0].due == k) begin
        chk("rnd resp_valid", resp_valid, N'(1) << q[0].c);
        lastf = mem_f(q[0].ip);
        chk("rnd resp_fields", resp_f(), lastf);
        void'(q.pop_front());
      end else begin
        chk("rnd resp_valid", resp_valid, 0);
        chk("rnd resp_hold", resp_f(), lastf);
      end
      g = -1;
      for (int i = 0; i < N; i++) begin
        j = (mptr + i) % N;
        if (g < 0 && pending[j]) g = j;
      end
      chk("rnd req_ready", req_ready,
          (g >= 0) ? (N'(1) << g) : '0);
      exp_mv = (g >= 0);
      if (g >= 0) begin
        q.push_back('{g, pip[g], k + LAT + 2});
        exp_mip = pip[g];
        mptr = (g + 1) % N;
        pending[g] = 1'b0;
      end
    end
    drain(6);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    run_table();
    seq_single();
    seq_all();
    seq_freeze();
    seq_same_cycle();
    seq_abort();
    seq_reset_inflight();
    run_random(600);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
